// File: rtl/mod_counter_prog.sv
// -----------------------------------------------------------------------------
// mod_counter_prog
//
// Runtime-programmable modulo up/down counter used for each calendar digit
// stage (sec/min/hour/day/month). Stages cascade by wiring one stage's carry
// (or borrow) into the next stage's tick. The modulus can change while running
// (days-in-month), and a set mode freezes time so that the user can nudge the
// digit with inc/dec pulses; those wrap but never generate carry/borrow.
//
// Build option (compile-time macro):
//   MOD_COUNTER_ONE_BASED_EN  defined   -> range 1..M   (day/month digits)
//                             undefined -> range 0..M-1 (default)
//   where M = max(mod_val, 1).
//
// Parameters:
//   MOD_MAX   largest modulus mod_val may take
//   BITS      width of count, mod_val and load_val
//
// Ports:
//   clock     in   rising-edge clock, the only clock
//   reset     in   synchronous, active-high reset
//   mod_val   in   runtime modulus (0 behaves as 1)
//   tick      in   run-mode advance strobe
//   down      in   tick direction: 0 = up, 1 = down
//   set       in   set mode: tick ignored, inc/dec active, no carry/borrow
//   inc       in   set-mode increment, one step per cycle high
//   dec       in   set-mode decrement, one step per cycle high
//   load      in   synchronous load of load_val (any mode), clamped to range
//   load_val  in   value to load
//   count     out  current value (registered)
//   carry     out  one-cycle pulse on run-mode up-wrap HI->LO
//   borrow    out  one-cycle pulse on run-mode down-wrap LO->HI
// -----------------------------------------------------------------------------
module mod_counter_prog #(
    parameter int MOD_MAX = 60,
    parameter int BITS    = $clog2(MOD_MAX + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITS-1:0] mod_val,
    input  logic            tick,
    input  logic            down,
    input  logic            set,
    input  logic            inc,
    input  logic            dec,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    output logic [BITS-1:0] count,
    output logic            carry,
    output logic            borrow
);

    // Range bounds are compared one bit wider than the count so that HI = M
    // (one-based build) can never overflow, whatever MOD_MAX is.
    localparam int W = BITS + 1;

    logic [W-1:0]    m_w;
    logic [W-1:0]    lo_w;
    logic [W-1:0]    hi_w;
    logic [W-1:0]    cnt_w;
    logic [W-1:0]    ldv_w;
    logic [BITS-1:0] lo_val;
    logic [BITS-1:0] hi_val;

    logic [BITS-1:0] count_q,  count_d;
    logic            carry_q,  carry_d;
    logic            borrow_q, borrow_d;

    assign m_w   = (mod_val == '0) ? W'(1) : {1'b0, mod_val};
    assign cnt_w = {1'b0, count_q};
    assign ldv_w = {1'b0, load_val};

`ifdef MOD_COUNTER_ONE_BASED_EN
    assign lo_w = W'(1);
    assign hi_w = m_w;
`else
    assign lo_w = '0;
    assign hi_w = m_w - W'(1);
`endif

    // hi_w never exceeds 2**BITS-1 (mod_val is BITS wide), so the top bit is
    // always zero and the truncation is lossless.
    assign lo_val = lo_w[BITS-1:0];
    assign hi_val = hi_w[BITS-1:0];

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;

        if (load) begin
            if (ldv_w > hi_w) begin
                count_d = hi_val;
            end else if (ldv_w < lo_w) begin
                count_d = lo_val;
            end else begin
                count_d = load_val;
            end
        end else if (cnt_w > hi_w) begin
            // Modulus just shrank below the current value: pull back to HI
            // and swallow whatever advance request arrived this cycle.
            count_d = hi_val;
        end else if (set) begin
            if (inc && !dec) begin
                count_d = (cnt_w == hi_w) ? lo_val : count_q + BITS'(1);
            end else if (dec && !inc) begin
                count_d = (cnt_w == lo_w) ? hi_val : count_q - BITS'(1);
            end
        end else if (tick) begin
            if (!down) begin
                if (cnt_w == hi_w) begin
                    count_d = lo_val;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + BITS'(1);
                end
            end else begin
                if (cnt_w == lo_w) begin
                    count_d  = hi_val;
                    borrow_d = 1'b1;
                end else begin
                    count_d = count_q - BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= lo_val;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count  = count_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_mod_counter_prog.sv
// -----------------------------------------------------------------------------
// Testbench for mod_counter_prog. Directed scenarios plus a randomized run,
// all checked against a behavioural model that works in terms of offsets from
// LO modulo M.
// -----------------------------------------------------------------------------
module tb_mod_counter_prog;

    localparam int MOD_MAX = 60;
    localparam int BITS    = $clog2(MOD_MAX + 1);
`ifdef MOD_COUNTER_ONE_BASED_EN
    localparam int LO_C = 1;
`else
    localparam int LO_C = 0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [BITS-1:0] mod_val = BITS'(60);
    logic            tick = 1'b0;
    logic            down = 1'b0;
    logic            set = 1'b0;
    logic            inc = 1'b0;
    logic            dec = 1'b0;
    logic            load = 1'b0;
    logic [BITS-1:0] load_val = '0;
    logic [BITS-1:0] count;
    logic            carry;
    logic            borrow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int exp_c  = 0;
    bit exp_cy = 1'b0;
    bit exp_bw = 1'b0;

    mod_counter_prog #(.MOD_MAX(MOD_MAX), .BITS(BITS)) dut (
        .clock    (clock),
        .reset    (reset),
        .mod_val  (mod_val),
        .tick     (tick),
        .down     (down),
        .set      (set),
        .inc      (inc),
        .dec      (dec),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .borrow   (borrow)
    );

    always #5 clock = ~clock;

    // Behavioural model: value = LO + offset, offset in 0..M-1, moves mod M.
    task automatic model_edge();
        int m, lo, hi, off;
        m  = (mod_val == 0) ? 1 : int'(mod_val);
        lo = LO_C;
        hi = lo + m - 1;
        exp_cy = 1'b0;
        exp_bw = 1'b0;
        if (reset) begin
            exp_c = lo;
        end else if (load) begin
            if (int'(load_val) > hi)      exp_c = hi;
            else if (int'(load_val) < lo) exp_c = lo;
            else                          exp_c = int'(load_val);
        end else if (exp_c > hi) begin
            exp_c = hi;
        end else if (set) begin
            if (inc && !dec)      exp_c = lo + (exp_c - lo + 1) % m;
            else if (dec && !inc) exp_c = lo + (exp_c - lo + m - 1) % m;
        end else if (tick) begin
            if (!down) begin
                off    = exp_c - lo + 1;
                exp_cy = (off == m);
                exp_c  = lo + off % m;
            end else begin
                exp_bw = (exp_c == lo);
                exp_c  = lo + (exp_c - lo + m - 1) % m;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        reset = 0; tick = 0; down = 0; set = 0; inc = 0; dec = 0; load = 0;
    endtask

    task automatic test_reset();
        quiet();
        mod_val = BITS'(60);
        reset = 1; tick = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C) || carry !== 1'b0 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d carry=%0b borrow=%0b, expected count=%0d carry=0 borrow=0",
                     count, carry, borrow, LO_C);
        end
        quiet();
    endtask

    task automatic test_up_wrap();
        quiet();
        mod_val = BITS'(60);
        load = 1; load_val = BITS'(58);
        step();
        checks++;
        if (count !== BITS'(58)) begin
            errors++;
            $display("FAIL up_wrap_load: count=%0d expected 58", count);
        end
        load = 0; tick = 1;
        step();
        checks++;
        if (count !== BITS'(59) || carry !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_59: count=%0d carry=%0b expected count=59 carry=0", count, carry);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== BITS'(exp_c) || carry !== exp_cy || borrow !== exp_bw) begin
                errors++;
                $display("FAIL up_wrap_%0d: count=%0d carry=%0b borrow=%0b expected count=%0d carry=%0b borrow=%0b",
                         i, count, carry, borrow, exp_c, exp_cy, exp_bw);
            end
        end
        tick = 0;
        step();
        checks++;
        if (carry !== 1'b0 || count !== BITS'(exp_c)) begin
            errors++;
            $display("FAIL up_wrap_idle: count=%0d carry=%0b expected count=%0d carry=0", count, carry, exp_c);
        end
    endtask

    task automatic test_down_wrap();
        quiet();
        mod_val = BITS'(24); down = 1;
        load = 1; load_val = BITS'(LO_C);
        step();
        load = 0; tick = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 23) || borrow !== 1'b1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap: count=%0d carry=%0b borrow=%0b expected count=%0d carry=0 borrow=1",
                     count, carry, borrow, LO_C + 23);
        end
        tick = 0;
        step();
        checks++;
        if (count !== BITS'(LO_C + 23) || borrow !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap_pulse: count=%0d borrow=%0b expected count=%0d borrow=0",
                     count, borrow, LO_C + 23);
        end
    endtask

    task automatic test_set_mode();
        quiet();
        mod_val = BITS'(60);
        load = 1; load_val = BITS'(LO_C + 59);
        step();
        load = 0; set = 1; tick = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 59) || carry !== 1'b0) begin
            errors++;
            $display("FAIL set_tick_ignored: count=%0d carry=%0b expected count=%0d carry=0",
                     count, carry, LO_C + 59);
        end
        tick = 0; inc = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C) || carry !== 1'b0 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL set_inc_wrap: count=%0d carry=%0b borrow=%0b expected count=%0d carry=0 borrow=0",
                     count, carry, borrow, LO_C);
        end
        inc = 0; dec = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 59) || carry !== 1'b0 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL set_dec_wrap: count=%0d carry=%0b borrow=%0b expected count=%0d carry=0 borrow=0",
                     count, carry, borrow, LO_C + 59);
        end
        inc = 1; dec = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 59)) begin
            errors++;
            $display("FAIL set_inc_dec_hold: count=%0d expected %0d", count, LO_C + 59);
        end
        set = 0; dec = 0; inc = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 59)) begin
            errors++;
            $display("FAIL run_inc_ignored: count=%0d expected %0d", count, LO_C + 59);
        end
        quiet();
    endtask

    task automatic test_clamp();
        quiet();
        mod_val = BITS'(31);
        load = 1; load_val = BITS'(30);
        step();
        load = 0; mod_val = BITS'(28); tick = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 27) || carry !== 1'b0) begin
            errors++;
            $display("FAIL clamp: count=%0d carry=%0b expected count=%0d carry=0", count, carry, LO_C + 27);
        end
        step();
        checks++;
        if (count !== BITS'(LO_C) || carry !== 1'b1) begin
            errors++;
            $display("FAIL clamp_next_tick: count=%0d carry=%0b expected count=%0d carry=1", count, carry, LO_C);
        end
        quiet();
    endtask

    task automatic test_reset_load();
        quiet();
        mod_val = BITS'(60);
        load = 1; load_val = BITS'(LO_C + 59);
        step();
        load = 0; reset = 1; tick = 1;
        step();
        checks++;
        if (count !== BITS'(LO_C) || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_on_wrap: count=%0d carry=%0b expected count=%0d carry=0", count, carry, LO_C);
        end
        quiet();
        // 99 does not fit in BITS; the widest representable value exercises the same clamp.
        load = 1; load_val = '1;
        step();
        checks++;
        if (count !== BITS'(LO_C + 59)) begin
            errors++;
            $display("FAIL load_clamp_hi: count=%0d expected %0d", count, LO_C + 59);
        end
        load_val = '0;
        step();
        checks++;
        if (count !== BITS'(LO_C)) begin
            errors++;
            $display("FAIL load_zero: count=%0d expected %0d", count, LO_C);
        end
        quiet();
    endtask

    task automatic test_mod_one();
        quiet();
        for (int mv = 0; mv < 2; mv++) begin
            mod_val = BITS'(mv);
            tick = 1; down = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                checks++;
                if (count !== BITS'(LO_C) || carry !== 1'b1 || borrow !== 1'b0) begin
                    errors++;
                    $display("FAIL mod%0d_up_%0d: count=%0d carry=%0b borrow=%0b expected count=%0d carry=1 borrow=0",
                             mv, i, count, carry, borrow, LO_C);
                end
            end
            down = 1;
            for (int i = 0; i < 2; i++) begin
                step();
                checks++;
                if (count !== BITS'(LO_C) || carry !== 1'b0 || borrow !== 1'b1) begin
                    errors++;
                    $display("FAIL mod%0d_down_%0d: count=%0d carry=%0b borrow=%0b expected count=%0d carry=0 borrow=1",
                             mv, i, count, carry, borrow, LO_C);
                end
            end
        end
        quiet();
    endtask

    task automatic test_random();
        quiet();
        mod_val = BITS'($urandom_range(1, MOD_MAX));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mod_val = BITS'($urandom_range(0, MOD_MAX));
            if ($urandom_range(0, 7) == 0)  set = ~set;
            reset    = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = BITS'($urandom_range(0, (1 << BITS) - 1));
            tick     = $urandom_range(0, 1);
            down     = $urandom_range(0, 1);
            inc      = $urandom_range(0, 1);
            dec      = $urandom_range(0, 1);
            step();
            checks++;
            if (count !== BITS'(exp_c) || carry !== exp_cy || borrow !== exp_bw) begin
                errors++;
                $display("FAIL random_%0d: count=%0d carry=%0b borrow=%0b expected count=%0d carry=%0b borrow=%0b",
                         i, count, carry, borrow, exp_c, exp_cy, exp_bw);
            end
        end
        quiet();
    endtask

    initial begin
        #2;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_set_mode();
        test_clamp();
        test_reset_load();
        test_mod_one();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
